// File: rtl/axi2ahb_rdata.sv
// AXI-to-AHB bridge read-data return path: tags AHB read beats with ID/last/response
// and queues them in a first-word fall-through FIFO that feeds the AXI R channel.
module axi2ahb_rdata #(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    // AXI R channel
    output logic [AXI_ID_WIDTH-1:0]   RID,
    output logic [AXI_DATA_WIDTH-1:0] RDATA,
    output logic [1:0]                RRESP,
    output logic                      RLAST,
    output logic                      RVALID,
    input  logic                      RREADY,
    // AHB data phase
    input  logic [AXI_DATA_WIDTH-1:0] HRDATA,
    input  logic                      HREADY,
    input  logic                      HRESP,
    // burst command
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [AXI_ID_WIDTH-1:0]   cmd_id_i,
    input  logic [7:0]                cmd_len_i,
    input  logic                      cmd_error_i,
    // address sequencer handshake
    input  logic                      ctrl_addr_issue_i,
    output logic                      ctrl_rdata_ready_o,
    output logic                      ctrl_rdata_done_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_S = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        ERRB  = 2'd2
    } state_e;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        logic                      last;
    } rbeat_t;

    state_e                  state_q, state_d;
    logic [AXI_ID_WIDTH-1:0] id_q, id_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              bcnt_q, bcnt_d;
    logic                    dphase_q;
    logic [CW-1:0]           outst_q, outst_d;

    rbeat_t                  mem_q [FIFO_DEPTH];
    logic [PW-1:0]           wptr_q, rptr_q;
    logic [CW-1:0]           fcnt_q, fcnt_d;

    logic                    push, pop, full, last_beat, burst_push, issue_acc;
    rbeat_t                  push_beat, head;
    logic [CW:0]             credit_sum;

    assign last_beat  = (bcnt_q == len_q);
    assign full       = (fcnt_q == DEPTH_C);
    assign RVALID     = (fcnt_q != '0);
    assign pop        = RVALID && RREADY;
    assign issue_acc  = ctrl_addr_issue_i && HREADY;
    assign burst_push = push && (state_q == BURST);

    // Command/burst FSM and beat formation
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        len_d     = len_q;
        bcnt_d    = bcnt_q;
        push      = 1'b0;
        push_beat = '0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    id_d    = cmd_id_i;
                    len_d   = cmd_len_i;
                    bcnt_d  = 8'd0;
                    state_d = cmd_error_i ? ERRB : BURST;
                end
            end
            BURST: begin
                if (dphase_q && HREADY) begin
                    push      = 1'b1;
                    push_beat = '{id: id_q, data: HRDATA,
                                  resp: HRESP ? 2'b10 : 2'b00, last: last_beat};
                end
            end
            ERRB: begin
                if (!full) begin
                    push      = 1'b1;
                    push_beat = '{id: id_q, data: '0, resp: 2'b10, last: last_beat};
                end
            end
            default: state_d = IDLE;
        endcase
        if (push) begin
            bcnt_d = bcnt_q + 8'd1;
            if (last_beat) state_d = IDLE;
        end
    end

    always_comb begin
        outst_d = outst_q;
        case ({issue_acc, burst_push})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_comb begin
        fcnt_d = fcnt_q;
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + CW'(1);
            2'b01:   fcnt_d = fcnt_q - CW'(1);
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q  <= IDLE;
            id_q     <= '0;
            len_q    <= '0;
            bcnt_q   <= '0;
            dphase_q <= 1'b0;
            outst_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            fcnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            if (HREADY) dphase_q <= ctrl_addr_issue_i;
            outst_q <= outst_d;
            fcnt_q  <= fcnt_d;
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge ACLK) begin
        if (push) mem_q[wptr_q] <= push_beat;
    end

    assign head = mem_q[rptr_q];
    assign {RID, RDATA, RRESP, RLAST} = RVALID ? head : '0;

    assign credit_sum         = {1'b0, fcnt_q} + {1'b0, outst_q};
    assign cmd_ready_o        = (state_q == IDLE);
    assign ctrl_rdata_ready_o = (state_q == BURST) && (credit_sum < DEPTH_S);
    assign ctrl_rdata_done_o  = push && last_beat;

    a_no_overflow: assert property (@(posedge ACLK) disable iff (ARESET)
        !(push && full && !pop));
    a_credit: assert property (@(posedge ACLK) disable iff (ARESET)
        !(ctrl_addr_issue_i && !ctrl_rdata_ready_o));

endmodule

// File: tb/tb_axi2ahb_rdata.sv
// Directed bench for axi2ahb_rdata: cycle table for a plain burst, hand sequences for corners.
module tb_axi2ahb_rdata;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    typedef struct {
        logic        cv;
        logic [7:0]  len;
        logic        iss;
        logic [31:0] hd;
        logic        cr, rdy, dn, rv;
        logic [31:0] rd;
        logic        rl;
    } vec_t;

    logic        ACLK = 1'b0, ARESET = 1'b1;
    logic        RID, RLAST, RVALID, RREADY;
    logic [31:0] RDATA, HRDATA;
    logic [1:0]  RRESP;
    logic        HREADY, HRESP;
    logic        cmd_valid_i, cmd_ready_o, cmd_id_i, cmd_error_i;
    logic [7:0]  cmd_len_i;
    logic        ctrl_addr_issue_i, ctrl_rdata_ready_o, ctrl_rdata_done_o;

    int total = 0, bad = 0;
    int ndone = 0;
    logic rdy_seen = 1'b0;
    beat_t rx[$], ex[$];
    beat_t mon_b;
    vec_t tv[8];

    axi2ahb_rdata #(.AXI_ID_WIDTH(1), .AXI_DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_id_i(cmd_id_i),
        .cmd_len_i(cmd_len_i), .cmd_error_i(cmd_error_i),
        .ctrl_addr_issue_i(ctrl_addr_issue_i), .ctrl_rdata_ready_o(ctrl_rdata_ready_o),
        .ctrl_rdata_done_o(ctrl_rdata_done_o)
    );

    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (RVALID && RREADY) begin
                mon_b = {RID, RDATA, RRESP, RLAST};
                rx.push_back(mon_b);
            end
            if (ctrl_rdata_done_o) ndone++;
            if (ctrl_rdata_ready_o) rdy_seen = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic expb(input logic id, input logic [31:0] d, input logic [1:0] r, input logic l);
        beat_t b;
        b = {id, d, r, l};
        ex.push_back(b);
    endtask

    task automatic check_rx(input string nm);
        chk({nm, "_nbeats"}, 64'(rx.size()), 64'(ex.size()));
        for (int i = 0; i < ex.size() && i < rx.size(); i++)
            chk($sformatf("%s_beat%0d", nm, i), 64'(rx[i]), 64'(ex[i]));
        rx.delete();
        ex.delete();
    endtask

    // Drive one AHB cycle from posedge+1 and advance to the next posedge+1.
    task automatic ahb(input logic iss, input logic hr, input logic hresp, input logic [31:0] hd);
        ctrl_addr_issue_i = iss;
        HREADY = hr;
        HRESP  = hresp;
        HRDATA = hd;
        @(posedge ACLK); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) ahb(1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic cmd(input logic id, input logic [7:0] len, input logic err);
        cmd_valid_i = 1'b1;
        cmd_id_i    = id;
        cmd_len_i   = len;
        cmd_error_i = err;
        @(negedge ACLK);
        chk("cmd_accept", 64'(cmd_ready_o), 64'd1);
        @(posedge ACLK); #1;
        cmd_valid_i = 1'b0;
        cmd_len_i   = 8'd0;
        cmd_error_i = 1'b0;
    endtask

    initial begin
        int issued, dp;
        logic iss;

        RREADY = 1'b0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        cmd_valid_i = 1'b0; cmd_id_i = 1'b0; cmd_len_i = '0; cmd_error_i = 1'b0;
        ctrl_addr_issue_i = 1'b0;

        tv[0] = '{1'b1, 8'd3, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
        tv[1] = '{1'b0, 8'd0, 1'b1, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0};
        tv[2] = '{1'b0, 8'd0, 1'b1, 32'hA000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0};
        tv[3] = '{1'b0, 8'd0, 1'b1, 32'hA000_0001, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA000_0000, 1'b0};
        tv[4] = '{1'b0, 8'd0, 1'b1, 32'hA000_0002, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA000_0001, 1'b0};
        tv[5] = '{1'b0, 8'd0, 1'b0, 32'hA000_0003, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA000_0002, 1'b0};
        tv[6] = '{1'b0, 8'd0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'hA000_0003, 1'b1};
        tv[7] = '{1'b0, 8'd0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};

        // reset state
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        chk("reset_outs",
            {RID, RDATA, RRESP, RLAST, RVALID, cmd_ready_o, ctrl_rdata_ready_o, ctrl_rdata_done_o},
            {1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        idle(1);

        // 1: id=1 len=3 burst, cycle-accurate table
        rx.delete(); ndone = 0; RREADY = 1'b1; cmd_id_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd_valid_i = tv[i].cv;
            cmd_len_i   = tv[i].len;
            ctrl_addr_issue_i = tv[i].iss;
            HRDATA = tv[i].hd;
            HREADY = 1'b1;
            @(negedge ACLK);
            chk($sformatf("t1_row%0d", i),
                {cmd_ready_o, ctrl_rdata_ready_o, ctrl_rdata_done_o, RVALID, RDATA, RLAST},
                {tv[i].cr, tv[i].rdy, tv[i].dn, tv[i].rv, tv[i].rd, tv[i].rl});
            @(posedge ACLK); #1;
        end
        cmd_valid_i = 1'b0; cmd_len_i = 8'd0; cmd_id_i = 1'b0;
        for (int i = 0; i < 4; i++) expb(1'b1, 32'hA000_0000 + 32'(i), 2'b00, i == 3);
        check_rx("t1");
        chk("t1_done", 64'(ndone), 64'd1);

        // 2: len=15 against 8-entry FIFO, sequencer obeys credit
        ndone = 0; RREADY = 1'b0;
        cmd(1'b0, 8'd15, 1'b0);
        issued = 0; dp = -1;
        for (int c = 0; c < 100; c++) begin
            if (c == 30) begin
                chk("t2_issued", 64'(issued), 64'd8);
                chk("t2_rdy_low", 64'(ctrl_rdata_ready_o), 64'd0);
                chk("t2_head", {RVALID, RDATA}, {1'b1, 32'hB000_0000});
                RREADY = 1'b1;
            end
            HRDATA = (dp >= 0) ? 32'hB000_0000 + 32'(dp) : 32'h0;
            HREADY = 1'b1;
            iss = ctrl_rdata_ready_o && (issued < 16);
            ctrl_addr_issue_i = iss;
            @(posedge ACLK); #1;
            if (iss) begin
                dp = issued;
                issued++;
            end else dp = -1;
        end
        ctrl_addr_issue_i = 1'b0; RREADY = 1'b0;
        for (int i = 0; i < 16; i++) expb(1'b0, 32'hB000_0000 + 32'(i), 2'b00, i == 15);
        check_rx("t2");
        chk("t2_done", 64'(ndone), 64'd1);

        // 3: error response on beat 2 with a wait cycle
        ndone = 0; RREADY = 1'b1;
        cmd(1'b1, 8'd3, 1'b0);
        ahb(1'b1, 1'b1, 1'b0, 32'h0);
        ahb(1'b1, 1'b1, 1'b0, 32'hC000_0000);
        ahb(1'b1, 1'b1, 1'b0, 32'hC000_0001);
        ahb(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        ahb(1'b0, 1'b1, 1'b1, 32'hC000_0002);
        ahb(1'b1, 1'b1, 1'b0, 32'h0);
        ahb(1'b0, 1'b1, 1'b0, 32'hC000_0003);
        idle(4);
        expb(1'b1, 32'hC000_0000, 2'b00, 1'b0);
        expb(1'b1, 32'hC000_0001, 2'b00, 1'b0);
        expb(1'b1, 32'hC000_0002, 2'b10, 1'b0);
        expb(1'b1, 32'hC000_0003, 2'b00, 1'b1);
        check_rx("t3");
        chk("t3_done", 64'(ndone), 64'd1);

        // 4: illegal command answered with SLVERR beats, no credits
        ndone = 0; rdy_seen = 1'b0; RREADY = 1'b1;
        cmd(1'b1, 8'd2, 1'b1);
        idle(6);
        chk("t4_no_rdy", 64'(rdy_seen), 64'd0);
        for (int i = 0; i < 3; i++) expb(1'b1, 32'h0, 2'b10, i == 2);
        check_rx("t4");
        chk("t4_done", 64'(ndone), 64'd1);

        // 5: three wait states in one data phase
        ndone = 0; RREADY = 1'b1;
        cmd(1'b0, 8'd0, 1'b0);
        ahb(1'b1, 1'b1, 1'b0, 32'h0);
        ahb(1'b0, 1'b0, 1'b0, 32'h1111_1111);
        ahb(1'b0, 1'b0, 1'b0, 32'h2222_2222);
        ahb(1'b0, 1'b0, 1'b0, 32'h3333_3333);
        ahb(1'b0, 1'b1, 1'b0, 32'hD5D5_0005);
        idle(3);
        expb(1'b0, 32'hD5D5_0005, 2'b00, 1'b1);
        check_rx("t5");
        chk("t5_done", 64'(ndone), 64'd1);

        // 6: reset with 4 beats queued, then a fresh burst
        ndone = 0; RREADY = 1'b0;
        cmd(1'b1, 8'd7, 1'b0);
        ahb(1'b1, 1'b1, 1'b0, 32'h0);
        ahb(1'b1, 1'b1, 1'b0, 32'hF000_0000);
        ahb(1'b1, 1'b1, 1'b0, 32'hF000_0001);
        ahb(1'b1, 1'b1, 1'b0, 32'hF000_0002);
        ahb(1'b0, 1'b1, 1'b0, 32'hF000_0003);
        chk("t6_queued", {RVALID, RDATA}, {1'b1, 32'hF000_0000});
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("t6_reset", {RVALID, cmd_ready_o, ctrl_rdata_ready_o}, {1'b0, 1'b1, 1'b0});
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        rx.delete(); ndone = 0; RREADY = 1'b1;
        cmd(1'b0, 8'd1, 1'b0);
        ahb(1'b1, 1'b1, 1'b0, 32'h0);
        ahb(1'b1, 1'b1, 1'b0, 32'hE000_0000);
        ahb(1'b0, 1'b1, 1'b0, 32'hE000_0001);
        idle(3);
        expb(1'b0, 32'hE000_0000, 2'b00, 1'b0);
        expb(1'b0, 32'hE000_0001, 2'b00, 1'b1);
        check_rx("t6");
        chk("t6_done", 64'(ndone), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
